// File: rtl/avaliador_execucao.sv
// Scores a live performance one expected entry at a time: pitch check,
// duration within a tolerance window, and a no-press timeout. Keeps
// saturating hit/error counts and ends the run on the last entry or on the
// error limit.
module avaliador_execucao #(
   parameter int NOTA_W    = 4,
   parameter int TEMPO_W   = 4,
   parameter int TOL       = 1,
   parameter int TIMEOUT   = 16,
   parameter int MAX_ERROS = 3,
   parameter int ERRO_W    = 3,
   parameter int ACERTO_W  = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                inicia,
   input  logic                metro_tick,
   input  logic [NOTA_W-1:0]   nota,
   input  logic                esp_valid,
   output logic                esp_ready,
   input  logic [NOTA_W-1:0]   esp_nota,
   input  logic [TEMPO_W-1:0]  esp_tempo,
   input  logic                esp_ultimo,
   output logic                res_valid,
   output logic [1:0]          res_codigo,
   output logic [ACERTO_W-1:0] acertos,
   output logic [ERRO_W-1:0]   erros,
   output logic                ativo,
   output logic                fim,
   output logic                fim_por_erro
);
   // Hold counter must reach 2^TEMPO_W+TOL; the wait counter must reach TIMEOUT.
   localparam int SEG_MAX = (1 << TEMPO_W) + TOL;
   localparam int CNT_MAX = (SEG_MAX > TIMEOUT) ? SEG_MAX : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIF_W   = CNT_W + 1;

   localparam logic [CNT_W-1:0]  SEG_LIM  = CNT_W'(SEG_MAX);
   localparam logic [CNT_W-1:0]  TO_ULT   = CNT_W'(TIMEOUT - 1);
   localparam logic [DIF_W-1:0]  TOL_D    = DIF_W'(TOL);
   localparam logic [ERRO_W-1:0] ERRO_LIM = ERRO_W'(MAX_ERROS);

   typedef enum logic [2:0] {
      OCIOSO,
      BUSCA,
      ESPERA,
      SEGURA,
      AVALIA,
      FIM
   } estado_t;

   estado_t             estado_reg;
   logic [CNT_W-1:0]    ticks_reg;
   logic [NOTA_W-1:0]   esp_nota_reg;
   logic [TEMPO_W-1:0]  esp_tempo_reg;
   logic                esp_ultimo_reg;
   logic [NOTA_W-1:0]   pressionada_reg;
   logic                res_valid_reg;
   logic [1:0]          res_codigo_reg;
   logic [ACERTO_W-1:0] acertos_reg;
   logic [ERRO_W-1:0]   erros_reg;
   logic                fim_por_erro_reg;

   logic [DIF_W-1:0]    medido;
   logic [DIF_W-1:0]    esperado;
   logic [DIF_W-1:0]    dif;
   logic                pontua;
   logic [1:0]          codigo_pont;

   // Decide whether this edge scores the entry and with which code.
   // The timeout fires on the tick that would bring the count to TIMEOUT, so
   // res_valid lands exactly one clock after that tick.
   always_comb begin
      medido      = DIF_W'(ticks_reg);
      esperado    = DIF_W'(esp_tempo_reg);
      dif         = (medido >= esperado) ? (medido - esperado) : (esperado - medido);
      pontua      = 1'b0;
      codigo_pont = 2'b00;
      case (estado_reg)
         ESPERA: begin
            if ((nota == '0) && metro_tick && (ticks_reg == TO_ULT)) begin
               pontua      = 1'b1;
               codigo_pont = 2'b11;
            end
         end
         SEGURA: begin
            if (nota == '0) begin
               pontua = 1'b1;
               if (pressionada_reg != esp_nota_reg) begin
                  codigo_pont = 2'b01;
               end else if (dif > TOL_D) begin
                  codigo_pont = 2'b10;
               end
            end
         end
         default: begin
            pontua      = 1'b0;
            codigo_pont = 2'b00;
         end
      endcase
   end

   // Run sequencing, tick counting and saturating score counters.
   // Any state change takes priority over a coincident tick, which is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_reg       <= OCIOSO;
         ticks_reg        <= '0;
         esp_nota_reg     <= '0;
         esp_tempo_reg    <= '0;
         esp_ultimo_reg   <= 1'b0;
         pressionada_reg  <= '0;
         res_valid_reg    <= 1'b0;
         res_codigo_reg   <= 2'b00;
         acertos_reg      <= '0;
         erros_reg        <= '0;
         fim_por_erro_reg <= 1'b0;
      end else begin
         res_valid_reg <= 1'b0;
         if (pontua) begin
            res_valid_reg  <= 1'b1;
            res_codigo_reg <= codigo_pont;
            if (codigo_pont == 2'b00) begin
               if (acertos_reg != '1) begin
                  acertos_reg <= acertos_reg + 1'b1;
               end
            end else if (erros_reg != '1) begin
               erros_reg <= erros_reg + 1'b1;
            end
         end
         case (estado_reg)
            OCIOSO, FIM: begin
               if (inicia) begin
                  estado_reg       <= BUSCA;
                  acertos_reg      <= '0;
                  erros_reg        <= '0;
                  fim_por_erro_reg <= 1'b0;
               end
            end
            BUSCA: begin
               if (esp_valid) begin
                  esp_nota_reg   <= esp_nota;
                  esp_tempo_reg  <= esp_tempo;
                  esp_ultimo_reg <= esp_ultimo;
                  ticks_reg      <= '0;
                  estado_reg     <= ESPERA;
               end
            end
            ESPERA: begin
               if (nota != '0) begin
                  ticks_reg       <= '0;
                  pressionada_reg <= nota;
                  estado_reg      <= SEGURA;
               end else if (pontua) begin
                  estado_reg <= AVALIA;
               end else if (metro_tick) begin
                  ticks_reg <= ticks_reg + 1'b1;
               end
            end
            SEGURA: begin
               if (nota == '0) begin
                  estado_reg <= AVALIA;
               end else if (metro_tick && (ticks_reg != SEG_LIM)) begin
                  ticks_reg <= ticks_reg + 1'b1;
               end
            end
            AVALIA: begin
               if (esp_ultimo_reg || (erros_reg == ERRO_LIM)) begin
                  estado_reg       <= FIM;
                  fim_por_erro_reg <= (erros_reg == ERRO_LIM);
               end else begin
                  estado_reg <= BUSCA;
               end
            end
            default: estado_reg <= OCIOSO;
         endcase
      end
   end

   assign esp_ready    = (estado_reg == BUSCA);
   assign ativo        = (estado_reg == BUSCA) || (estado_reg == ESPERA) ||
                         (estado_reg == SEGURA) || (estado_reg == AVALIA);
   assign fim          = (estado_reg == FIM);
   assign res_valid    = res_valid_reg;
   assign res_codigo   = res_codigo_reg;
   assign acertos      = acertos_reg;
   assign erros        = erros_reg;
   assign fim_por_erro = fim_por_erro_reg;

endmodule

// File: tb/tb_avaliador_execucao.sv
// Bench for avaliador_execucao: drives whole entries (fetch, wait, press,
// hold, release) and derives the expected result of each entry from the
// ticks it actually delivered, then checks every output on every cycle.
module tb_avaliador_execucao;
   localparam int NOTA_W    = 4;
   localparam int TEMPO_W   = 4;
   localparam int TOL       = 1;
   localparam int TIMEOUT   = 16;
   localparam int MAX_ERROS = 3;
   localparam int ERRO_W    = 3;
   localparam int ACERTO_W  = 5;
   localparam int SEG_MAX   = (1 << TEMPO_W) + TOL;
   localparam int AC_SAT    = (1 << ACERTO_W) - 1;
   localparam int ER_SAT    = (1 << ERRO_W) - 1;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                inicia = 1'b0;
   logic                metro_tick = 1'b0;
   logic [NOTA_W-1:0]   nota = '0;
   logic                esp_valid = 1'b0;
   logic                esp_ready;
   logic [NOTA_W-1:0]   esp_nota = '0;
   logic [TEMPO_W-1:0]  esp_tempo = '0;
   logic                esp_ultimo = 1'b0;
   logic                res_valid;
   logic [1:0]          res_codigo;
   logic [ACERTO_W-1:0] acertos;
   logic [ERRO_W-1:0]   erros;
   logic                ativo;
   logic                fim;
   logic                fim_por_erro;

   avaliador_execucao #(
      .NOTA_W(NOTA_W), .TEMPO_W(TEMPO_W), .TOL(TOL), .TIMEOUT(TIMEOUT),
      .MAX_ERROS(MAX_ERROS), .ERRO_W(ERRO_W), .ACERTO_W(ACERTO_W)
   ) dut (
      .clock(clock), .reset(reset), .inicia(inicia), .metro_tick(metro_tick),
      .nota(nota), .esp_valid(esp_valid), .esp_ready(esp_ready),
      .esp_nota(esp_nota), .esp_tempo(esp_tempo), .esp_ultimo(esp_ultimo),
      .res_valid(res_valid), .res_codigo(res_codigo), .acertos(acertos),
      .erros(erros), .ativo(ativo), .fim(fim), .fim_por_erro(fim_por_erro)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   int n_entry = 0;

   // expected outputs, valid from the edge just passed
   bit       chk_on = 1'b0;
   bit       e_ready = 0, e_rv = 0, e_ativo = 0, e_fim = 0, e_fpe = 0;
   bit [1:0] e_code = 0;
   int       e_ac = 0, e_er = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   // compare all outputs against the model on the falling edge
   always @(negedge clock) begin
      if (chk_on) begin
         chk("esp_ready", esp_ready, e_ready);
         chk("res_valid", res_valid, e_rv);
         chk("ativo", ativo, e_ativo);
         chk("fim", fim, e_fim);
         chk("fim_por_erro", fim_por_erro, e_fpe);
         chk("acertos", acertos, e_ac);
         chk("erros", erros, e_er);
         if (e_rv) chk("res_codigo", res_codigo, e_code);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic start_run();
      inicia = 1'b1;
      metro_tick = 1'($urandom);
      step();
      inicia = 1'b0;
      e_ready = 1; e_ativo = 1; e_fim = 0; e_fpe = 0; e_ac = 0; e_er = 0; e_rv = 0;
   endtask

   // One complete entry. Returns the model code and the code the DUT showed.
   task automatic play_entry(input logic [3:0] en, input logic [3:0] et, input bit eu,
                             input bit do_to, input logic [3:0] pn, input int wait_t,
                             input int hold_t, input bit tick_rel,
                             output logic [1:0] mcode, output logic [1:0] dcode);
      int t;
      int h;
      int meas;
      int d;
      // idle in fetch with junk on ignored inputs
      repeat ($urandom_range(0, 2)) begin
         esp_valid = 1'b0;
         inicia = 1'($urandom);
         metro_tick = 1'($urandom);
         nota = 4'($urandom);
         esp_nota = 4'($urandom);
         esp_tempo = 4'($urandom);
         esp_ultimo = 1'($urandom);
         step();
      end
      inicia = 1'b0;
      esp_valid = 1'b1; esp_nota = en; esp_tempo = et; esp_ultimo = eu;
      nota = 4'($urandom); metro_tick = 1'($urandom);
      step();
      e_ready = 0;
      esp_valid = 1'b0; esp_nota = 4'($urandom); esp_tempo = 4'($urandom);
      esp_ultimo = 1'($urandom);
      nota = '0;
      t = 0;
      if (do_to) begin
         while (t < TIMEOUT) begin
            metro_tick = 1'($urandom);
            if (metro_tick) t++;
            step();
         end
         mcode = 2'b11;
      end else begin
         while (t < wait_t) begin
            metro_tick = 1'($urandom);
            if (metro_tick) t++;
            step();
         end
         nota = pn; metro_tick = 1'($urandom);
         step();
         h = 0;
         while (h < hold_t) begin
            metro_tick = 1'($urandom);
            if (metro_tick) h++;
            nota = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : pn;
            step();
         end
         nota = '0;
         metro_tick = tick_rel ? 1'b1 : 1'($urandom);
         step();
         meas = (h > SEG_MAX) ? SEG_MAX : h;
         d = meas - int'(et);
         if (d < 0) d = -d;
         if (pn != en) mcode = 2'b01;
         else if (d > TOL) mcode = 2'b10;
         else mcode = 2'b00;
      end
      e_rv = 1; e_code = mcode;
      if (mcode == 2'b00) begin
         if (e_ac < AC_SAT) e_ac++;
      end else if (e_er < ER_SAT) begin
         e_er++;
      end
      dcode = res_codigo;
      n_entry++;
      $display("entry %0d: exp=(%0d,%0d,%0d) code model=%0d dut=%0d hits=%0d errs=%0d",
               n_entry, en, et, eu, mcode, dcode, e_ac, e_er);
      metro_tick = 1'($urandom); nota = '0;
      step();
      e_rv = 0;
      if (eu || e_er == MAX_ERROS) begin
         e_fim = 1; e_ativo = 0; e_ready = 0; e_fpe = (e_er == MAX_ERROS);
      end else begin
         e_ready = 1;
      end
   endtask

   logic [1:0] mc, dc;
   logic [3:0] r_en, r_et, r_pn;
   bit         r_eu, r_to, r_tr;
   int         r_wt, r_ht, nrun;

   initial begin
      // reset state
      reset = 1'b1;
      step();
      step();
      chk_on = 1'b1;
      chk("rst_esp_ready", esp_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_codigo", res_codigo, 0);
      chk("rst_ativo", ativo, 0);
      chk("rst_fim", fim, 0);
      reset = 1'b0;
      step();

      // correct last entry
      start_run();
      play_entry(4'd5, 4'd4, 1'b1, 1'b0, 4'd5, 2, 4, 1'b0, mc, dc);
      chk("dir_ok_model", mc, 0);
      chk("dir_ok_dut", dc, 0);
      chk("dir_ok_acertos", acertos, 1);
      chk("dir_ok_fim", fim, 1);
      chk("dir_ok_fpe", fim_por_erro, 0);
      repeat (3) step();

      // timeout, wrong note, wrong tempo
      start_run();
      play_entry(4'd5, 4'd4, 1'b0, 1'b1, 4'd5, 0, 0, 1'b0, mc, dc);
      chk("dir_to_model", mc, 3);
      chk("dir_to_dut", dc, 3);
      chk("dir_to_ready_back", esp_ready, 1);
      play_entry(4'd5, 4'd4, 1'b0, 1'b0, 4'd7, 1, 4, 1'b0, mc, dc);
      chk("dir_nota_model", mc, 1);
      chk("dir_nota_dut", dc, 1);
      play_entry(4'd5, 4'd4, 1'b1, 1'b0, 4'd5, 0, 6, 1'b0, mc, dc);
      chk("dir_tempo_model", mc, 2);
      chk("dir_tempo_dut", dc, 2);
      chk("dir_tempo_erros", erros, 3);
      repeat (2) step();

      // three wrong notes hit the error limit
      start_run();
      for (int i = 0; i < 3; i++) play_entry(4'd2, 4'd3, 1'b0, 1'b0, 4'd9, 0, 3, 1'b0, mc, dc);
      repeat (4) step();
      chk("lim_fim", fim, 1);
      chk("lim_fpe", fim_por_erro, 1);
      chk("lim_ready", esp_ready, 0);

      // release on a tick: 3 ticks counted, expected 5 -> tempo error
      start_run();
      play_entry(4'd6, 4'd5, 1'b1, 1'b0, 4'd6, 0, 3, 1'b1, mc, dc);
      chk("rel_tick_model", mc, 2);
      chk("rel_tick_dut", dc, 2);

      // reset while holding a key
      start_run();
      play_entry(4'd3, 4'd2, 1'b0, 1'b0, 4'd3, 1, 2, 1'b0, mc, dc);
      esp_valid = 1'b1; esp_nota = 4'd3; esp_tempo = 4'd2; esp_ultimo = 1'b0; metro_tick = 1'b0;
      step();
      e_ready = 0;
      esp_valid = 1'b0;
      nota = 4'd3; step();
      metro_tick = 1'b1; step();
      metro_tick = 1'b0; step();
      reset = 1'b1; nota = '0;
      step();
      reset = 1'b0;
      e_ready = 0; e_ativo = 0; e_fim = 0; e_fpe = 0; e_ac = 0; e_er = 0; e_rv = 0;
      chk("mid_rst_ativo", ativo, 0);
      chk("mid_rst_acertos", acertos, 0);
      chk("mid_rst_res_codigo", res_codigo, 0);
      repeat (2) step();
      start_run();
      play_entry(4'd3, 4'd2, 1'b1, 1'b0, 4'd3, 0, 2, 1'b0, mc, dc);
      chk("mid_rst_restart", acertos, 1);

      // hit counter saturation
      start_run();
      for (int i = 0; i < 34; i++)
         play_entry(4'd2, 4'd0, (i == 33), 1'b0, 4'd2, 0, 0, 1'b0, mc, dc);
      chk("sat_acertos", acertos, AC_SAT);

      // random runs
      for (int r = 0; r < 6; r++) begin
         start_run();
         nrun = 0;
         while (!e_fim && nrun < 40) begin
            r_en = 4'($urandom_range(1, 15));
            r_et = 4'($urandom_range(0, 15));
            r_eu = ($urandom_range(0, 9) == 0) || (nrun == 39);
            r_to = ($urandom_range(0, 7) == 0);
            r_pn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : r_en;
            r_wt = $urandom_range(0, TIMEOUT - 1);
            if ($urandom_range(0, 2) == 0) r_ht = $urandom_range(0, 20);
            else r_ht = int'(r_et) + int'($urandom_range(0, 4)) - 2;
            if (r_ht < 0) r_ht = 0;
            r_tr = 1'($urandom);
            play_entry(r_en, r_et, r_eu, r_to, r_pn, r_wt, r_ht, r_tr, mc, dc);
            nrun++;
         end
         repeat (2) step();
      end

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
